// File: rtl/translated_pipelined_mux.sv
`default_nettype none
// ============================================================================
// Module      : translated_pipelined_mux
// Description : Translates an address into a word index and returns the
//               selected input word through a two-stage valid/ready pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module translated_pipelined_mux #(
    parameter int WORD_WIDTH       = 36,
    parameter int ADDR_WIDTH       = 11,
    parameter int INPUT_COUNT      = 8,
    parameter int INPUT_BASE_ADDR  = 123,
    parameter int INPUT_ADDR_WIDTH = 3,
    parameter int MISS_COUNT_WIDTH = 8,
    parameter int TOTAL_WIDTH      = INPUT_COUNT * WORD_WIDTH
) (
    input  logic                        clock,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ADDR_WIDTH-1:0]       addr,
    input  logic [TOTAL_WIDTH-1:0]      in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_WIDTH-1:0]       out,
    output logic                        out_hit,
    output logic [MISS_COUNT_WIDTH-1:0] miss_count
);

    localparam int c_slots = 2 ** INPUT_ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_base_lo = (ADDR_WIDTH + 1)'(INPUT_BASE_ADDR);
    localparam logic [ADDR_WIDTH:0] c_base_hi = (ADDR_WIDTH + 1)'(INPUT_BASE_ADDR + INPUT_COUNT);
    localparam logic [INPUT_ADDR_WIDTH-1:0] c_base_idx = INPUT_ADDR_WIDTH'(INPUT_BASE_ADDR);
    localparam logic [MISS_COUNT_WIDTH-1:0] c_miss_one = MISS_COUNT_WIDTH'(1);
    localparam logic [MISS_COUNT_WIDTH-1:0] c_miss_max = '1;

    logic [WORD_WIDTH-1:0]       w_words [c_slots];
    logic [ADDR_WIDTH:0]         w_addr_ext;
    logic                        w_hit;
    logic [INPUT_ADDR_WIDTH-1:0] w_index;
    logic [WORD_WIDTH-1:0]       w_sel_word;
    logic                        w_accept;
    logic                        w_s1_adv;

    logic                        r_s1_valid;
    logic                        r_s1_hit;
    logic [WORD_WIDTH-1:0]       r_s1_word;
    logic                        r_s2_valid;
    logic                        r_s2_hit;
    logic [WORD_WIDTH-1:0]       r_s2_word;
    logic [MISS_COUNT_WIDTH-1:0] r_miss_count;

    // Unpopulated index slots read as zero so a non-power-of-two count
    // never selects beyond the packed bus.
    generate
        for (genvar k = 0; k < c_slots; k++) begin : g_words
            if (k < INPUT_COUNT) begin : g_live
                assign w_words[k] = in[k*WORD_WIDTH +: WORD_WIDTH];
            end else begin : g_pad
                assign w_words[k] = '0;
            end
        end
    endgenerate

    // One extra bit keeps the upper window bound from wrapping.
    assign w_addr_ext = {1'b0, addr};
    assign w_hit      = (w_addr_ext >= c_base_lo) && (w_addr_ext < c_base_hi);
    assign w_index    = addr[INPUT_ADDR_WIDTH-1:0] - c_base_idx;
    assign w_sel_word = w_hit ? w_words[w_index] : '0;

    assign w_s1_adv = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready = !r_s1_valid || w_s1_adv;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_s1_valid <= 1'b0;
            r_s1_hit   <= 1'b0;
            r_s1_word  <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_hit   <= w_hit;
            r_s1_word  <= w_sel_word;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_s2_valid <= 1'b0;
            r_s2_hit   <= 1'b0;
            r_s2_word  <= '0;
        end else if (w_s1_adv) begin
            r_s2_valid <= 1'b1;
            r_s2_hit   <= r_s1_hit;
            r_s2_word  <= r_s1_word;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_miss_count <= '0;
        end else if (w_accept && !w_hit && (r_miss_count != c_miss_max)) begin
            r_miss_count <= r_miss_count + c_miss_one;
        end
    end

    assign out_valid  = r_s2_valid;
    assign out        = r_s2_word;
    assign out_hit    = r_s2_hit;
    assign miss_count = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_translated_pipelined_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_translated_pipelined_mux
// Description : Directed and randomized checks against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_translated_pipelined_mux;

    localparam int W    = 36;
    localparam int AW   = 11;
    localparam int CNT  = 8;
    localparam int BASE = 123;
    localparam int IAW  = 3;
    localparam int MW   = 8;
    localparam int TW   = CNT * W;
    localparam int MMAX = (1 << MW) - 1;

    logic          clock = 1'b0;
    logic          clear = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [TW-1:0] in_bus = '0;

    logic          in_ready, out_valid, out_hit;
    logic [W-1:0]  out;
    logic [MW-1:0] miss_count;

    logic          s_in_ready, s_out_valid, s_out_hit;
    logic [W-1:0]  s_out;
    logic [1:0]    s_miss;

    translated_pipelined_mux u_dut (
        .clock(clock), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .addr(addr), .in(in_bus), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_hit(out_hit), .miss_count(miss_count)
    );

    translated_pipelined_mux #(.MISS_COUNT_WIDTH(2)) u_dut_sat (
        .clock(clock), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
        .addr(addr), .in(in_bus), .out_valid(s_out_valid), .out_ready(out_ready),
        .out(s_out), .out_hit(s_out_hit), .miss_count(s_miss)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: in-flight results in order, each tagged with edges since accept.
    typedef struct {
        logic [W-1:0] word;
        bit           hit;
        int           age;
    } ent_t;

    ent_t mq[$];
    int   mcnt = 0;
    ent_t m_e;
    bit   m_rdy, m_vld;

    function automatic ent_t lookup(input int a, input logic [TW-1:0] bus);
        ent_t r;
        r.age = 0;
        if (a >= BASE && a < BASE + CNT) begin
            r.hit  = 1'b1;
            r.word = bus[(a - BASE) * W +: W];
        end else begin
            r.hit  = 1'b0;
            r.word = '0;
        end
        return r;
    endfunction

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            mq.delete();
            mcnt = 0;
        end else begin
            m_rdy = (mq.size() < 2) || out_ready;
            m_vld = (mq.size() > 0) && (mq[0].age >= 1);
            if (m_vld && out_ready) void'(mq.pop_front());
            foreach (mq[i]) mq[i].age = mq[i].age + 1;
            if (in_valid && m_rdy) begin
                m_e = lookup(int'(addr), in_bus);
                mq.push_back(m_e);
                if (!m_e.hit && mcnt < MMAX) mcnt = mcnt + 1;
            end
        end
    end

    logic [W:0] cap[$];
    always @(posedge clock) begin
        if (!clear && out_valid && out_ready) cap.push_back({out_hit, out});
    end

    bit c_ev;
    always @(negedge clock) begin
        c_ev = (mq.size() > 0) && (mq[0].age >= 1);
        chk("out_valid", 64'(out_valid), 64'(c_ev));
        chk("in_ready", 64'(in_ready), 64'((mq.size() < 2) || out_ready));
        chk("miss_count", 64'(miss_count), 64'(mcnt));
        if (c_ev) begin
            chk("out", 64'(out), 64'(mq[0].word));
            chk("out_hit", 64'(out_hit), 64'(mq[0].hit));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(input int a);
        logic acc;
        int   guard;
        acc = 1'b0;
        guard = 0;
        in_valid = 1'b1;
        addr = AW'(a);
        while (!acc && guard < 50) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            guard++;
        end
        if (!acc) chk("send_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #3 clear = 1'b1;
        @(posedge clock);
        #3 clear = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic load_default();
        for (int k = 0; k < CNT; k++) in_bus[k*W +: W] = W'(k + 'h100);
    endtask

    int sat_exp[5] = '{1, 2, 3, 3, 3};

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        load_default();
        cyc(3);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out", 64'(out), 64'(0));
        chk("rst_out_hit", 64'(out_hit), 64'(0));
        chk("rst_miss", 64'(miss_count), 64'(0));
        #2 clear = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // Single hit, minimum latency
        out_ready = 1'b1;
        send(125);
        cyc(1);
        chk("hit_valid", 64'(out_valid), 64'(1));
        chk("hit_out", 64'(out), 64'h102);
        chk("hit_flag", 64'(out_hit), 64'(1));
        chk("hit_miss", 64'(miss_count), 64'(0));
        cyc(3);

        // Window edges, back to back
        cap.delete();
        send(122); send(131); send(123); send(130);
        cyc(4);
        chk("edge_count", 64'(cap.size()), 64'(4));
        if (cap.size() == 4) begin
            chk("edge_122", 64'(cap[0]), 64'({1'b0, 36'h0}));
            chk("edge_131", 64'(cap[1]), 64'({1'b0, 36'h0}));
            chk("edge_123", 64'(cap[2]), 64'({1'b1, 36'h100}));
            chk("edge_130", 64'(cap[3]), 64'({1'b1, 36'h107}));
        end
        chk("edge_miss", 64'(miss_count), 64'(2));

        // Backpressure
        cap.delete();
        out_ready = 1'b0;
        send(123); send(124);
        in_valid = 1'b1;
        addr = AW'(125);
        @(negedge clock);
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_out", 64'(out), 64'h100);
        cyc(2);
        @(negedge clock);
        chk("bp_hold_out", 64'(out), 64'h100);
        chk("bp_hold_valid", 64'(out_valid), 64'(1));
        @(posedge clock);
        #1 out_ready = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        cyc(5);
        chk("bp_count", 64'(cap.size()), 64'(3));
        if (cap.size() == 3) begin
            chk("bp_0", 64'(cap[0]), 64'({1'b1, 36'h100}));
            chk("bp_1", 64'(cap[1]), 64'({1'b1, 36'h101}));
            chk("bp_2", 64'(cap[2]), 64'({1'b1, 36'h102}));
        end

        // Sample isolation
        cap.delete();
        send(124);
        in_bus[1*W +: W] = 36'hBADC0FFEE;
        cyc(3);
        chk("iso_count", 64'(cap.size()), 64'(1));
        if (cap.size() == 1) chk("iso_word", 64'(cap[0]), 64'({1'b1, 36'h101}));
        load_default();

        // Saturation on the narrow-counter instance
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(5);
            chk("sat_seq", 64'(s_miss), 64'(sat_exp[i]));
        end
        cyc(3);

        // Clear mid-flight
        out_ready = 1'b0;
        send(123); send(124);
        #2 clear = 1'b1;
        #1;
        chk("mid_valid", 64'(out_valid), 64'(0));
        chk("mid_out", 64'(out), 64'(0));
        chk("mid_miss", 64'(miss_count), 64'(0));
        chk("mid_in_ready", 64'(in_ready), 64'(1));
        cap.delete();
        @(posedge clock);
        #3 clear = 1'b0;
        @(posedge clock);
        #1 out_ready = 1'b1;
        cyc(5);
        chk("mid_none", 64'(cap.size()), 64'(0));

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) addr = AW'($urandom_range(0, (1 << AW) - 1));
            else addr = AW'($urandom_range(BASE - 4, BASE + CNT + 4));
            for (int k = 0; k < CNT; k++) in_bus[k*W +: W] = W'({$urandom, $urandom});
            if ($urandom_range(0, 399) == 0) begin
                #2 clear = 1'b1;
                #1 clear = 1'b0;
            end
            @(posedge clock);
            #1;
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
